// File: rtl/axi_lite_arb_pkg.sv
// Shared types and the round-robin pick helper for the AXI4-Lite arbiter.
package axi_lite_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int PTR_W       = 3;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  // First requester at or after ptr wins; unused upper request bits must be zero.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                     input logic [PTR_W-1:0]       ptr);
    logic [MAX_MASTERS-1:0] gnt;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (!found && (i >= int'(ptr)) && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (!found && (i < int'(ptr)) && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick, pointer moves past the served master.
module rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic [N-1:0] served,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;
  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] pick;
  logic                   unused_pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, ptr_q);
    grant          = pick[N-1:0];
  end

  assign unused_pick = ^pick;

  // Pointer lands on the master after the one just served, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      ptr_d = (advance && served[i]) ? ((i == N-1) ? '0 : PTR_W'(i + 1)) : ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter with independent round-robin write and read paths,
// one outstanding transaction per direction, combinational forwarding once granted.
module axi_lite_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       s_awaddr,
  input  logic [NUM_MASTERS*3-1:0]                s_awprot,
  input  logic [NUM_MASTERS-1:0]                  s_awvalid,
  output logic [NUM_MASTERS-1:0]                  s_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]       s_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   s_wstrb,
  input  logic [NUM_MASTERS-1:0]                  s_wvalid,
  output logic [NUM_MASTERS-1:0]                  s_wready,
  output logic [1:0]                              s_bresp,
  output logic [NUM_MASTERS-1:0]                  s_bvalid,
  input  logic [NUM_MASTERS-1:0]                  s_bready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       s_araddr,
  input  logic [NUM_MASTERS*3-1:0]                s_arprot,
  input  logic [NUM_MASTERS-1:0]                  s_arvalid,
  output logic [NUM_MASTERS-1:0]                  s_arready,
  output logic [DATA_WIDTH-1:0]                   s_rdata,
  output logic [1:0]                              s_rresp,
  output logic [NUM_MASTERS-1:0]                  s_rvalid,
  input  logic [NUM_MASTERS-1:0]                  s_rready,
  output logic [ADDR_WIDTH-1:0]                   m_awaddr,
  output logic [2:0]                              m_awprot,
  output logic                                    m_awvalid,
  input  logic                                    m_awready,
  output logic [DATA_WIDTH-1:0]                   m_wdata,
  output logic [DATA_WIDTH/8-1:0]                 m_wstrb,
  output logic                                    m_wvalid,
  input  logic                                    m_wready,
  input  logic [1:0]                              m_bresp,
  input  logic                                    m_bvalid,
  output logic                                    m_bready,
  output logic [ADDR_WIDTH-1:0]                   m_araddr,
  output logic [2:0]                              m_arprot,
  output logic                                    m_arvalid,
  input  logic                                    m_arready,
  input  logic [DATA_WIDTH-1:0]                   m_rdata,
  input  logic [1:0]                              m_rresp,
  input  logic                                    m_rvalid,
  output logic                                    m_rready,
  output logic [NUM_MASTERS-1:0]                  wr_grant,
  output logic [NUM_MASTERS-1:0]                  rd_grant
);

  localparam int N      = NUM_MASTERS;
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e    wr_state_q, wr_state_d;
  logic [N-1:0] wr_grant_q, wr_grant_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic         wr_adv;
  logic         aw_hs, w_hs;
  logic [N-1:0] wr_pick;

  rd_state_e    rd_state_q, rd_state_d;
  logic [N-1:0] rd_grant_q, rd_grant_d;
  logic         rd_adv;
  logic [N-1:0] rd_pick;

  rr_arbiter #(.N(N)) u_wr_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (s_awvalid),
    .advance (wr_adv),
    .served  (wr_grant_q),
    .grant   (wr_pick)
  );

  rr_arbiter #(.N(N)) u_rd_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (s_arvalid),
    .advance (rd_adv),
    .served  (rd_grant_q),
    .grant   (rd_pick)
  );

  // Write path: next state plus AND-OR muxing from the one-hot grant.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_adv     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    m_awaddr   = '0;
    m_awprot   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = 2'b00;
    case (wr_state_q)
      WR_IDLE: begin
        if (|s_awvalid) begin
          wr_grant_d = wr_pick;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_ADDR;
        end else begin
          wr_grant_d = '0;
        end
      end
      WR_ADDR: begin
        for (int i = 0; i < N; i++) begin
          m_awaddr = m_awaddr | (s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{wr_grant_q[i]}});
          m_awprot = m_awprot | (s_awprot[i*3 +: 3] & {3{wr_grant_q[i]}});
          m_wdata  = m_wdata  | (s_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_grant_q[i]}});
          m_wstrb  = m_wstrb  | (s_wstrb[i*STRB_W +: STRB_W] & {STRB_W{wr_grant_q[i]}});
        end
        m_awvalid = (|(s_awvalid & wr_grant_q)) & ~aw_done_q;
        m_wvalid  = (|(s_wvalid & wr_grant_q)) & ~w_done_q;
        s_awready = wr_grant_q & {N{m_awready & ~aw_done_q}};
        s_wready  = wr_grant_q & {N{m_wready & ~w_done_q}};
        aw_hs     = m_awvalid & m_awready;
        w_hs      = m_wvalid & m_wready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_ADDR;
        end
      end
      WR_RESP: begin
        m_bready = |(s_bready & wr_grant_q);
        s_bvalid = wr_grant_q & {N{m_bvalid}};
        s_bresp  = m_bresp;
        if (m_bvalid && m_bready) begin
          wr_adv     = 1'b1;
          wr_grant_d = '0;
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: begin
        wr_grant_d = '0;
        wr_state_d = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      wr_grant_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read path: one address handshake, then forward R to the granted master.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_adv     = 1'b0;
    m_araddr   = '0;
    m_arprot   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    case (rd_state_q)
      RD_IDLE: begin
        if (|s_arvalid) begin
          rd_grant_d = rd_pick;
          rd_state_d = RD_ADDR;
        end else begin
          rd_grant_d = '0;
        end
      end
      RD_ADDR: begin
        for (int i = 0; i < N; i++) begin
          m_araddr = m_araddr | (s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{rd_grant_q[i]}});
          m_arprot = m_arprot | (s_arprot[i*3 +: 3] & {3{rd_grant_q[i]}});
        end
        m_arvalid = |(s_arvalid & rd_grant_q);
        s_arready = rd_grant_q & {N{m_arready}};
        if (m_arvalid && m_arready) begin
          rd_state_d = RD_DATA;
        end else begin
          rd_state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        m_rready = |(s_rready & rd_grant_q);
        s_rvalid = rd_grant_q & {N{m_rvalid}};
        s_rdata  = m_rdata;
        s_rresp  = m_rresp;
        if (m_rvalid && m_rready) begin
          rd_adv     = 1'b1;
          rd_grant_d = '0;
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_DATA;
        end
      end
      default: begin
        rd_grant_d = '0;
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      rd_grant_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
    end
  end

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;

endmodule
